// File: rtl/counter_pkg.sv
// counter_pkg: shared boundary-mode type and direction constants for the up/down counter
package counter_pkg;
    typedef enum logic {WRAP = 1'b0, SATURATE = 1'b1} mode_e;
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;
endpackage

// File: rtl/counter_prescaler.sv
// counter_prescaler: counts enabled cycles 0..PRESCALE-1 and ticks on the last one
module counter_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    logic [PW-1:0] cnt_q, cnt_d;
    assign tick = enable && (cnt_q == PW'(PRESCALE - 1));
    always_comb cnt_d = clear ? '0 : !enable ? cnt_q : tick ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/updown_counter_param.sv
// updown_counter_param: prescaled up/down counter with wrap or saturate boundary handling
module updown_counter_param
    import counter_pkg::*;
#(
    parameter int              WIDTH    = 8,
    parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter int              PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             dir,
    input  logic             mode,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             sat
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);
    logic             tick, at_edge;
    logic [WIDTH-1:0] count_d, count_q;
    logic             wrap_d, wrap_q, sat_d, sat_q;
    mode_e            mode_s;
    // a load restarts the prescale period as well as the count
    counter_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear | load),
        .enable (enable),
        .tick   (tick)
    );
    always_comb begin
        mode_s  = mode_e'(mode);
        at_edge = (dir == DIR_UP) ? (count_q == MAX) : (count_q == '0);
        count_d = count_q;
        wrap_d  = 1'b0;
        sat_d   = sat_q;
        if (clear) begin
            count_d = '0;
            sat_d   = 1'b0;
        end else if (load) begin
            count_d = (load_val > MAX) ? MAX : load_val;
        end else if (tick) begin
            if (!at_edge) begin
                count_d = (dir == DIR_UP) ? count_q + 1'b1 : count_q - 1'b1;
            end else if (mode_s == SATURATE) begin
                sat_d = 1'b1;
            end else begin
                count_d = (dir == DIR_UP) ? '0 : MAX;
                wrap_d  = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            sat_q   <= sat_d;
        end
    end
    assign count = count_q;
    assign wrap  = wrap_q;
    assign sat   = sat_q;
endmodule

// File: tb/tb_updown_counter_param.sv
// tb_updown_counter_param: three configurations driven in parallel and checked against an arithmetic model
module tb_updown_counter_param;
    logic       clk = 1'b0;
    logic       reset, enable, dir, mode, clear, load;
    logic [7:0] load_val;
    logic [7:0] cnt_o [3];
    logic       wrap_o [3];
    logic       sat_o [3];
    int         mx [3] = '{255, 9, 255};
    int         ps [3] = '{1, 1, 4};
    int         m_cnt [3], m_pre [3];
    bit         m_wrap [3], m_sat [3];
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;

    updown_counter_param u_d0 (
        .clk(clk), .reset(reset), .enable(enable), .dir(dir), .mode(mode), .clear(clear),
        .load(load), .load_val(load_val), .count(cnt_o[0]), .wrap(wrap_o[0]), .sat(sat_o[0])
    );
    updown_counter_param #(.MAX_VAL(9)) u_d1 (
        .clk(clk), .reset(reset), .enable(enable), .dir(dir), .mode(mode), .clear(clear),
        .load(load), .load_val(load_val), .count(cnt_o[1]), .wrap(wrap_o[1]), .sat(sat_o[1])
    );
    updown_counter_param #(.PRESCALE(4)) u_d2 (
        .clk(clk), .reset(reset), .enable(enable), .dir(dir), .mode(mode), .clear(clear),
        .load(load), .load_val(load_val), .count(cnt_o[2]), .wrap(wrap_o[2]), .sat(sat_o[2])
    );

    // Model: count lives on the ring 0..mx, the prescaler is a plain tally of enabled cycles.
    task automatic cyc();
        for (int k = 0; k < 3; k++) begin
            m_wrap[k] = 1'b0;
            if (reset || clear) begin
                m_cnt[k] = 0;
                m_pre[k] = 0;
                m_sat[k] = 1'b0;
            end else if (load) begin
                m_cnt[k] = (int'(load_val) > mx[k]) ? mx[k] : int'(load_val);
                m_pre[k] = 0;
            end else if (enable) begin
                m_pre[k]++;
                if (m_pre[k] == ps[k]) begin
                    m_pre[k] = 0;
                    if ((dir && m_cnt[k] == mx[k]) || (!dir && m_cnt[k] == 0)) begin
                        if (mode) m_sat[k] = 1'b1;
                        else begin
                            m_cnt[k] = (m_cnt[k] + (dir ? 1 : mx[k])) % (mx[k] + 1);
                            m_wrap[k] = 1'b1;
                        end
                    end else m_cnt[k] += dir ? 1 : -1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        {reset, enable, dir, mode, clear, load} = '0;
        load_val = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; load = 1'b1; load_val = 8'd77; dir = 1'b1;
        cyc();
        for (int k = 0; k < 3; k++) begin
            checks += 3;
            if (cnt_o[k] !== 8'd0) begin errors++; $display("FAIL reset_count[%0d] got %0d exp 0", k, cnt_o[k]); end
            if (wrap_o[k] !== 1'b0) begin errors++; $display("FAIL reset_wrap[%0d] got %b exp 0", k, wrap_o[k]); end
            if (sat_o[k] !== 1'b0) begin errors++; $display("FAIL reset_sat[%0d] got %b exp 0", k, sat_o[k]); end
        end
        idle();
    endtask

    task automatic test_count_up();
        enable = 1'b1; dir = 1'b1;
        repeat (20) cyc();
        checks += 5;
        if (cnt_o[0] !== 8'd20) begin errors++; $display("FAIL up20_count got %0d exp 20", cnt_o[0]); end
        if (wrap_o[0] !== 1'b0 || sat_o[0] !== 1'b0) begin errors++; $display("FAIL up20_flags got %b%b exp 00", wrap_o[0], sat_o[0]); end
        if (cnt_o[2] !== 8'd5) begin errors++; $display("FAIL up20_presc_count got %0d exp 5", cnt_o[2]); end
        if (cnt_o[1] !== 8'(m_cnt[1])) begin errors++; $display("FAIL up20_max9_count got %0d exp %0d", cnt_o[1], m_cnt[1]); end
        if (wrap_o[1] !== m_wrap[1]) begin errors++; $display("FAIL up20_max9_wrap got %b exp %b", wrap_o[1], m_wrap[1]); end
        idle();
    endtask

    task automatic test_wrap();
        int pulses = 0, at = 0;
        load = 1'b1; load_val = 8'd250;
        cyc();
        load = 1'b0; enable = 1'b1; dir = 1'b1; mode = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            if (wrap_o[0] === 1'b1) begin pulses++; at = i; end
            checks++;
            if (wrap_o[1] !== m_wrap[1] || cnt_o[1] !== 8'(m_cnt[1])) begin
                errors++; $display("FAIL wrap_max9 edge %0d got %0d/%b exp %0d/%b", i, cnt_o[1], wrap_o[1], m_cnt[1], m_wrap[1]);
            end
        end
        checks += 3;
        if (cnt_o[0] !== 8'd4) begin errors++; $display("FAIL wrap_up_count got %0d exp 4", cnt_o[0]); end
        if (pulses != 1) begin errors++; $display("FAIL wrap_up_pulses got %0d exp 1", pulses); end
        if (at != 6) begin errors++; $display("FAIL wrap_up_edge got %0d exp 6", at); end
        dir = 1'b0; pulses = 0;
        repeat (5) begin
            cyc();
            if (wrap_o[0] === 1'b1) pulses++;
        end
        checks += 2;
        if (cnt_o[0] !== 8'd255) begin errors++; $display("FAIL wrap_down_count got %0d exp 255", cnt_o[0]); end
        if (pulses != 1) begin errors++; $display("FAIL wrap_down_pulses got %0d exp 1", pulses); end
        idle();
    endtask

    task automatic test_saturate();
        mode = 1'b1; load = 1'b1; load_val = 8'd250;
        cyc();
        load = 1'b0; enable = 1'b1; dir = 1'b1;
        repeat (10) begin
            cyc();
            checks++;
            if (wrap_o[0] !== 1'b0) begin errors++; $display("FAIL sat_no_wrap got %b exp 0", wrap_o[0]); end
        end
        checks += 2;
        if (cnt_o[0] !== 8'd255) begin errors++; $display("FAIL sat_count got %0d exp 255", cnt_o[0]); end
        if (sat_o[0] !== 1'b1) begin errors++; $display("FAIL sat_flag got %b exp 1", sat_o[0]); end
        enable = 1'b0; clear = 1'b1;
        cyc();
        checks += 2;
        if (cnt_o[0] !== 8'd0) begin errors++; $display("FAIL sat_clear_count got %0d exp 0", cnt_o[0]); end
        if (sat_o[0] !== 1'b0) begin errors++; $display("FAIL sat_clear_flag got %b exp 0", sat_o[0]); end
        idle();
    endtask

    task automatic test_max_val();
        load = 1'b1; load_val = 8'd0;
        cyc();
        load = 1'b0; enable = 1'b1; dir = 1'b0; mode = 1'b0;
        repeat (3) cyc();
        checks++;
        if (cnt_o[1] !== 8'd7) begin errors++; $display("FAIL max9_down_count got %0d exp 7", cnt_o[1]); end
        load = 1'b1; load_val = 8'd15;
        cyc();
        checks += 2;
        if (cnt_o[1] !== 8'd9) begin errors++; $display("FAIL max9_load_clamp got %0d exp 9", cnt_o[1]); end
        if (cnt_o[0] !== 8'd15) begin errors++; $display("FAIL load15_count got %0d exp 15", cnt_o[0]); end
        idle();
    endtask

    task automatic test_prescale();
        logic [7:0] held;
        clear = 1'b1;
        cyc();
        clear = 1'b0; enable = 1'b1; dir = 1'b1;
        repeat (10) cyc();
        held = cnt_o[2];
        checks++;
        if (held !== 8'd2) begin errors++; $display("FAIL presc_mid_count got %0d exp 2", held); end
        enable = 1'b0;
        repeat (3) begin
            cyc();
            checks++;
            if (cnt_o[2] !== held) begin errors++; $display("FAIL presc_hold got %0d exp %0d", cnt_o[2], held); end
        end
        enable = 1'b1;
        repeat (10) cyc();
        checks++;
        if (cnt_o[2] !== 8'd5) begin errors++; $display("FAIL presc_count got %0d exp 5", cnt_o[2]); end
        idle();
    endtask

    task automatic test_priority();
        enable = 1'b1; dir = 1'b1; load = 1'b1; load_val = 8'd12;
        cyc();
        checks++;
        if (cnt_o[0] !== 8'd12) begin errors++; $display("FAIL load_wins got %0d exp 12", cnt_o[0]); end
        load = 1'b0; reset = 1'b1;
        cyc();
        checks++;
        if (cnt_o[0] !== 8'd0) begin errors++; $display("FAIL mid_reset got %0d exp 0", cnt_o[0]); end
        reset = 1'b0;
        cyc();
        checks++;
        if (cnt_o[0] !== 8'd1) begin errors++; $display("FAIL resume_after_reset got %0d exp 1", cnt_o[0]); end
        load = 1'b1; load_val = 8'd255;
        cyc();
        load_val = 8'd7;
        cyc();
        checks += 2;
        if (cnt_o[0] !== 8'd7) begin errors++; $display("FAIL load_at_top got %0d exp 7", cnt_o[0]); end
        if (wrap_o[0] !== 1'b0) begin errors++; $display("FAIL load_suppress_wrap got %b exp 0", wrap_o[0]); end
        load_val = 8'd255;
        cyc();
        load = 1'b0; clear = 1'b1;
        cyc();
        checks += 2;
        if (cnt_o[0] !== 8'd0) begin errors++; $display("FAIL clear_at_top got %0d exp 0", cnt_o[0]); end
        if (wrap_o[0] !== 1'b0) begin errors++; $display("FAIL clear_suppress_wrap got %b exp 0", wrap_o[0]); end
        clear = 1'b1; load = 1'b1; load_val = 8'd33;
        cyc();
        checks++;
        if (cnt_o[0] !== 8'd0) begin errors++; $display("FAIL clear_over_load got %0d exp 0", cnt_o[0]); end
        idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset    = ($urandom_range(0, 59) == 0);
            clear    = ($urandom_range(0, 39) == 0);
            load     = ($urandom_range(0, 19) == 0);
            enable   = ($urandom_range(0, 3) != 0);
            dir      = ($urandom_range(0, 9) < ((i / 100) % 2 == 0 ? 8 : 2));
            mode     = ($urandom_range(0, 9) < ((i / 150) % 2 == 0 ? 1 : 8));
            load_val = 8'($urandom);
            cyc();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (cnt_o[k] !== 8'(m_cnt[k]) || wrap_o[k] !== m_wrap[k] || sat_o[k] !== m_sat[k]) begin
                    errors++;
                    $display("FAIL random[%0d] cyc %0d got c=%0d w=%b s=%b exp c=%0d w=%b s=%b",
                             k, i, cnt_o[k], wrap_o[k], sat_o[k], m_cnt[k], m_wrap[k], m_sat[k]);
                end
            end
        end
        idle();
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout reached");
        $fatal(1);
    end

    initial begin
        idle();
        test_reset();
        test_count_up();
        test_wrap();
        test_saturate();
        test_max_val();
        test_prescale();
        test_priority();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
